// File: rtl/oq_fifo2mem_writer.sv
// Writes cropped packet words into per-queue circular SRAM regions, prepends a
// length header, tracks per-queue occupancy and drops packets that cannot fit.
//
// state | meaning
// IDLE  | waiting for the first word of a packet; admission decided here
// WRITE | storing data words of an admitted packet
// DROP  | consuming the rest of a rejected packet without writing
// HDR   | writing the length header and committing the packet
module oq_fifo2mem_writer #(
    parameter int DATA_WIDTH     = 256,
    parameter int BYTE_CNT_WIDTH = 6,
    parameter int NUM_QUEUES     = 5,
    parameter int QUEUE_ID_WIDTH = 3,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int QUEUE_SIZE     = 104857,
    parameter int MAX_PKT_WORDS  = 48
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     din_data,
    input  logic [BYTE_CNT_WIDTH-1:0] din_bytes,
    input  logic                      din_last,
    input  logic [NUM_QUEUES-1:0]     din_oq,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic                      mem_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]     mem_wr_data,
    input  logic                      free_valid,
    input  logic [QUEUE_ID_WIDTH-1:0] free_queue,
    input  logic [MEM_ADDR_WIDTH-1:0] free_words,
    output logic                      pkt_commit,
    output logic [QUEUE_ID_WIDTH-1:0] commit_queue,
    output logic [MEM_ADDR_WIDTH-1:0] commit_words,
    output logic                      pkt_drop,
    output logic [QUEUE_ID_WIDTH-1:0] drop_queue
);

    // A queue admits a packet only if a worst-case packet plus header still fits.
    localparam int OCC_LIMIT = QUEUE_SIZE - MAX_PKT_WORDS - 1;

    typedef enum logic [1:0] {IDLE, WRITE, DROP, HDR} state_t;

    state_t state, state_nxt;

    logic [MEM_ADDR_WIDTH-1:0] wr_ptr  [NUM_QUEUES];
    logic [MEM_ADDR_WIDTH-1:0] occ     [NUM_QUEUES];
    logic [MEM_ADDR_WIDTH-1:0] occ_nxt [NUM_QUEUES];

    logic [QUEUE_ID_WIDTH-1:0] cur_q;
    logic [MEM_ADDR_WIDTH-1:0] hdr_addr;
    logic [MEM_ADDR_WIDTH-1:0] nxt_addr;
    logic [15:0]               wcnt;
    logic [15:0]               bytes;
    logic                      trunc;

    logic [QUEUE_ID_WIDTH-1:0] sel_q;
    logic                      sel_none;
    logic                      admit;
    logic                      accept;
    logic                      do_data_wr;
    logic                      do_hdr_wr;
    logic                      do_drop;
    logic [QUEUE_ID_WIDTH-1:0] wr_q;
    logic [MEM_ADDR_WIDTH-1:0] data_addr;
    logic [DATA_WIDTH-1:0]     hdr_word;

    function automatic logic [MEM_ADDR_WIDTH-1:0] region_base(input logic [QUEUE_ID_WIDTH-1:0] q);
        return MEM_ADDR_WIDTH'(int'(q) * QUEUE_SIZE);
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] next_addr(input logic [MEM_ADDR_WIDTH-1:0] a,
                                                           input logic [QUEUE_ID_WIDTH-1:0] q);
        logic [MEM_ADDR_WIDTH-1:0] b;
        b = region_base(q);
        return (a == b + MEM_ADDR_WIDTH'(QUEUE_SIZE - 1)) ? b : a + 1'b1;
    endfunction

    always_comb begin
        sel_q    = '0;
        sel_none = 1'b1;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (din_oq[i]) begin
                sel_q    = QUEUE_ID_WIDTH'(i);
                sel_none = 1'b0;
            end
        end
        admit = !sel_none && (occ[sel_q] <= MEM_ADDR_WIDTH'(OCC_LIMIT));
    end

    assign accept = din_valid && !reset && (state != HDR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (admit) state_nxt = din_last ? HDR : WRITE;
                    else       state_nxt = din_last ? IDLE : DROP;
                end
            end
            WRITE:   if (accept && din_last) state_nxt = HDR;
            DROP:    if (accept && din_last) state_nxt = IDLE;
            HDR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        do_data_wr = 1'b0;
        do_hdr_wr  = 1'b0;
        do_drop    = 1'b0;
        case (state)
            IDLE: begin
                din_ready  = !reset;
                do_data_wr = accept && admit;
                do_drop    = accept && !admit;
            end
            WRITE: begin
                din_ready  = !reset;
                do_data_wr = accept && (wcnt < 16'(MAX_PKT_WORDS));
            end
            DROP:    din_ready = !reset;
            HDR:     do_hdr_wr = 1'b1;
            default: din_ready = 1'b0;
        endcase
    end

    assign wr_q      = (state == IDLE) ? sel_q : cur_q;
    assign data_addr = (state == IDLE) ? next_addr(wr_ptr[sel_q], sel_q) : nxt_addr;

    always_comb begin
        hdr_word        = '0;
        hdr_word[15:0]  = bytes;
        hdr_word[31:16] = wcnt;
        hdr_word[32]    = trunc;
    end

    // Occupancy counts a write when it is scheduled, so admission sees in-flight words.
    always_comb begin
        logic                    inc;
        logic [MEM_ADDR_WIDTH:0] sum;
        logic [MEM_ADDR_WIDTH:0] dec;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            inc        = (do_data_wr || do_hdr_wr) && (wr_q == QUEUE_ID_WIDTH'(i));
            sum        = {1'b0, occ[i]} + (MEM_ADDR_WIDTH + 1)'(inc);
            dec        = (free_valid && free_queue == QUEUE_ID_WIDTH'(i)) ? {1'b0, free_words} : '0;
            occ_nxt[i] = (dec > sum) ? '0 : MEM_ADDR_WIDTH'(sum - dec);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wr_en    <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            pkt_commit   <= 1'b0;
            commit_queue <= '0;
            commit_words <= '0;
            pkt_drop     <= 1'b0;
            drop_queue   <= '0;
            cur_q        <= '0;
            hdr_addr     <= '0;
            nxt_addr     <= '0;
            wcnt         <= '0;
            bytes        <= '0;
            trunc        <= 1'b0;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                wr_ptr[i] <= MEM_ADDR_WIDTH'(i * QUEUE_SIZE);
                occ[i]    <= '0;
            end
        end else begin
            mem_wr_en  <= do_data_wr || do_hdr_wr;
            pkt_commit <= do_hdr_wr;
            pkt_drop   <= do_drop;
            for (int i = 0; i < NUM_QUEUES; i++) occ[i] <= occ_nxt[i];

            if (do_data_wr) begin
                mem_wr_addr <= data_addr;
                mem_wr_data <= din_data;
                nxt_addr    <= next_addr(data_addr, wr_q);
            end else if (do_hdr_wr) begin
                mem_wr_addr <= hdr_addr;
                mem_wr_data <= hdr_word;
            end

            if (do_drop) drop_queue <= sel_q;

            if (state == IDLE && do_data_wr) begin
                cur_q    <= sel_q;
                hdr_addr <= wr_ptr[sel_q];
                wcnt     <= 16'd1;
                bytes    <= 16'(din_bytes);
                trunc    <= 1'b0;
            end else if (state == WRITE && accept) begin
                if (do_data_wr) begin
                    wcnt  <= wcnt + 16'd1;
                    bytes <= bytes + 16'(din_bytes);
                end else begin
                    trunc <= 1'b1;
                end
            end

            if (do_hdr_wr) begin
                wr_ptr[cur_q] <= nxt_addr;
                commit_queue  <= cur_q;
                commit_words  <= MEM_ADDR_WIDTH'(wcnt) + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oq_fifo2mem_writer.sv
// Directed bench for oq_fifo2mem_writer using a small queue region so that
// wrap-around and the admission threshold are reachable in a short run.
module tb_oq_fifo2mem_writer;
    localparam int QS = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] din_data;
    logic [5:0]   din_bytes;
    logic         din_last;
    logic [4:0]   din_oq;
    logic         din_valid;
    logic         din_ready;
    logic         mem_wr_en;
    logic [18:0]  mem_wr_addr;
    logic [255:0] mem_wr_data;
    logic         free_valid;
    logic [2:0]   free_queue;
    logic [18:0]  free_words;
    logic         pkt_commit;
    logic [2:0]   commit_queue;
    logic [18:0]  commit_words;
    logic         pkt_drop;
    logic [2:0]   drop_queue;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [18:0]  wa [$];
    logic [255:0] wd [$];
    int           wc [$];
    logic [2:0]   cq [$];
    logic [18:0]  cw [$];
    int           cc [$];
    logic [2:0]   dq [$];
    int           dc [$];

    oq_fifo2mem_writer #(.QUEUE_SIZE(QS)) dut (
        .clk(clk), .reset(reset),
        .din_data(din_data), .din_bytes(din_bytes), .din_last(din_last),
        .din_oq(din_oq), .din_valid(din_valid), .din_ready(din_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .free_valid(free_valid), .free_queue(free_queue), .free_words(free_words),
        .pkt_commit(pkt_commit), .commit_queue(commit_queue), .commit_words(commit_words),
        .pkt_drop(pkt_drop), .drop_queue(drop_queue)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr_en)  begin wa.push_back(mem_wr_addr); wd.push_back(mem_wr_data); wc.push_back(cyc); end
        if (pkt_commit) begin cq.push_back(commit_queue); cw.push_back(commit_words); cc.push_back(cyc); end
        if (pkt_drop)   begin dq.push_back(drop_queue); dc.push_back(cyc); end
    end

    function automatic logic [255:0] hdr_w(input int b, input int w, input bit t);
        logic [255:0] h;
        h = '0; h[15:0] = 16'(b); h[31:16] = 16'(w); h[32] = t;
        return h;
    endfunction

    function automatic logic [255:0] dat(input int tag, input int k);
        return {224'(tag), 32'(k)};
    endfunction

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); cq.delete(); cw.delete(); cc.delete(); dq.delete(); dc.delete();
    endtask

    task automatic send_pkt(input logic [4:0] oq, input int n, input logic [5:0] last_bytes, input int tag,
                            input int free_idx, input logic [2:0] fq, input logic [18:0] fw,
                            output int first_cyc, output int last_cyc);
        first_cyc = 0; last_cyc = 0;
        for (int k = 0; k < n; k++) begin
            int g = 0;
            din_valid = 1'b1; din_oq = oq; din_last = (k == n - 1);
            din_bytes = (k == n - 1) ? last_bytes : 6'd32; din_data = dat(tag, k);
            while (din_ready !== 1'b1) begin
                @(negedge clk); g++;
                if (g > 20) begin
                    checks++; errors++;
                    $display("FAIL ready_timeout: din_ready=%b want 1", din_ready);
                    break;
                end
            end
            if (k == free_idx) begin free_valid = 1'b1; free_queue = fq; free_words = fw; end
            if (k == 0) first_cyc = cyc;
            if (k == n - 1) last_cyc = cyc;
            @(negedge clk);
            free_valid = 1'b0;
        end
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    task automatic pulse_free(input logic [2:0] fq, input logic [18:0] fw);
        free_valid = 1'b1; free_queue = fq; free_words = fw;
        @(negedge clk);
        free_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; din_valid = 1'b0; din_last = 1'b0; din_oq = '0; din_bytes = '0; din_data = '0;
        free_valid = 1'b0; free_queue = '0; free_words = '0;
        repeat (3) @(negedge clk);
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", din_ready); end
        checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== '0) begin errors++; $display("FAIL rst_mem: en=%b addr=%0d", mem_wr_en, mem_wr_addr); end
        checks++; if ({pkt_commit, commit_queue, commit_words, pkt_drop, drop_queue} !== '0) begin
            errors++; $display("FAIL rst_status: commit=%b cq=%0d cw=%0d drop=%b dq=%0d", pkt_commit, commit_queue, commit_words, pkt_drop, drop_queue); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", din_ready); end
        clear_logs();
    endtask

    task automatic test_basic();
        int f, l;
        clear_logs();
        send_pkt(5'b00100, 3, 6'd10, 2, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 4) begin errors++; $display("FAIL basic_nwr: got %0d want 4", wa.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (wa[k] !== 19'(2*QS+1+k)) begin errors++; $display("FAIL basic_addr%0d: got %0d want %0d", k, wa[k], 2*QS+1+k); end
                checks++; if (wd[k] !== dat(2, k)) begin errors++; $display("FAIL basic_data%0d: got %0h want %0h", k, wd[k], dat(2, k)); end
                checks++; if (wc[k] !== f+1+k) begin errors++; $display("FAIL basic_lat%0d: got %0d want %0d", k, wc[k], f+1+k); end
            end
            checks++; if (wa[3] !== 19'(2*QS)) begin errors++; $display("FAIL basic_hdr_addr: got %0d want %0d", wa[3], 2*QS); end
            checks++; if (wd[3] !== hdr_w(74, 3, 0)) begin errors++; $display("FAIL basic_hdr: got %0h want %0h", wd[3], hdr_w(74, 3, 0)); end
            checks++; if (wc[3] !== l+2) begin errors++; $display("FAIL basic_hdr_lat: got %0d want %0d", wc[3], l+2); end
        end
        checks++;
        if (cq.size() != 1) begin errors++; $display("FAIL basic_ncommit: got %0d want 1", cq.size()); end
        else if (cq[0] !== 3'd2 || cw[0] !== 19'd4 || cc[0] !== l+2) begin
            errors++; $display("FAIL basic_commit: q=%0d w=%0d cyc=%0d want q=2 w=4 cyc=%0d", cq[0], cw[0], cc[0], l+2); end
        checks++; if (dut.occ[2] !== 19'd4) begin errors++; $display("FAIL basic_occ: got %0d want 4", dut.occ[2]); end
    endtask

    task automatic test_single();
        int f, l;
        clear_logs();
        send_pkt(5'b00001, 1, 6'd20, 7, -1, 3'd0, 19'd0, f, l);
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL single_ready_hdr: got %b want 0", din_ready); end
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b want 1", din_ready); end
        repeat (2) @(negedge clk);
        checks++;
        if (wa.size() != 2) begin errors++; $display("FAIL single_nwr: got %0d want 2", wa.size()); end
        else if (wa[0] !== 19'd1 || wd[0] !== dat(7, 0) || wa[1] !== 19'd0 || wd[1] !== hdr_w(20, 1, 0) || wc[1] !== wc[0]+1) begin
            errors++; $display("FAIL single_wr: a0=%0d a1=%0d hdr=%0h want a0=1 a1=0 hdr=%0h", wa[0], wa[1], wd[1], hdr_w(20, 1, 0)); end
    endtask

    task automatic test_drop();
        int f, l;
        clear_logs();
        send_pkt(5'b00010, 15, 6'd32, 1, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++; if (dut.occ[1] !== 19'd16) begin errors++; $display("FAIL drop_fill_occ: got %0d want 16", dut.occ[1]); end
        clear_logs();
        send_pkt(5'b00010, 3, 6'd5, 1, -1, 3'd0, 19'd0, f, l);
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b want 1", din_ready); end
        repeat (3) @(negedge clk);
        checks++; if (wa.size() != 0 || cq.size() != 0) begin errors++; $display("FAIL drop_nowrite: writes=%0d commits=%0d want 0 0", wa.size(), cq.size()); end
        checks++;
        if (dq.size() != 1) begin errors++; $display("FAIL drop_npulse: got %0d want 1", dq.size()); end
        else if (dq[0] !== 3'd1 || dc[0] !== f+1) begin errors++; $display("FAIL drop_pulse: q=%0d cyc=%0d want q=1 cyc=%0d", dq[0], dc[0], f+1); end
        clear_logs();
        send_pkt(5'b00000, 1, 6'd8, 9, -1, 3'd0, 19'd0, f, l);
        repeat (2) @(negedge clk);
        checks++; if (dq.size() != 1 || dq[0] !== 3'd0) begin errors++; $display("FAIL drop_noq: count=%0d want 1 with queue 0", dq.size()); end
        pulse_free(3'd1, 19'd100);
        checks++; if (dut.occ[1] !== 19'd0) begin errors++; $display("FAIL drop_free_sat: got %0d want 0", dut.occ[1]); end
        clear_logs();
        send_pkt(5'b00010, 2, 6'd4, 3, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 3) begin errors++; $display("FAIL drop_readmit_nwr: got %0d want 3", wa.size()); end
        else if (wa[0] !== 19'd81 || wa[1] !== 19'd82 || wa[2] !== 19'd80 || wd[2] !== hdr_w(36, 2, 0)) begin
            errors++; $display("FAIL drop_readmit: a=%0d,%0d,%0d want 81,82,80", wa[0], wa[1], wa[2]); end
        checks++; if (cq.size() != 1 || cw[0] !== 19'd3) begin errors++; $display("FAIL drop_readmit_commit: count=%0d want 1 with 3 words", cq.size()); end
    endtask

    task automatic test_wrap();
        int f, l;
        send_pkt(5'b01000, 48, 6'd32, 4, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        pulse_free(3'd3, 19'd49);
        send_pkt(5'b01000, 12, 6'd32, 4, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++; if (dut.occ[3] !== 19'd13) begin errors++; $display("FAIL wrap_occ: got %0d want 13", dut.occ[3]); end
        clear_logs();
        send_pkt(5'b01000, 3, 6'd1, 5, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 4) begin errors++; $display("FAIL wrap_nwr: got %0d want 4", wa.size()); end
        else begin
            checks++; if (wa[0] !== 19'(4*QS-1)) begin errors++; $display("FAIL wrap_d0: got %0d want %0d", wa[0], 4*QS-1); end
            checks++; if (wa[1] !== 19'(3*QS)) begin errors++; $display("FAIL wrap_d1: got %0d want %0d", wa[1], 3*QS); end
            checks++; if (wa[2] !== 19'(3*QS+1)) begin errors++; $display("FAIL wrap_d2: got %0d want %0d", wa[2], 3*QS+1); end
            checks++; if (wa[3] !== 19'(4*QS-2) || wd[3] !== hdr_w(65, 3, 0)) begin
                errors++; $display("FAIL wrap_hdr: addr=%0d data=%0h want %0d %0h", wa[3], wd[3], 4*QS-2, hdr_w(65, 3, 0)); end
        end
    endtask

    task automatic test_trunc();
        int f, l;
        clear_logs();
        send_pkt(5'b10000, 50, 6'd32, 6, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++;
        if (wa.size() != 49) begin errors++; $display("FAIL trunc_nwr: got %0d want 49", wa.size()); end
        else begin
            checks++; if (wa[47] !== 19'(4*QS+48)) begin errors++; $display("FAIL trunc_last_data: got %0d want %0d", wa[47], 4*QS+48); end
            checks++; if (wa[48] !== 19'(4*QS) || wd[48][31:16] !== 16'd48 || wd[48][32] !== 1'b1) begin
                errors++; $display("FAIL trunc_hdr: addr=%0d words=%0d trunc=%b want %0d 48 1", wa[48], wd[48][31:16], wd[48][32], 4*QS); end
            checks++; if (wc[48] !== l+2) begin errors++; $display("FAIL trunc_hdr_lat: got %0d want %0d", wc[48], l+2); end
        end
        checks++; if (cq.size() != 1 || cq[0] !== 3'd4 || cw[0] !== 19'd49) begin errors++; $display("FAIL trunc_commit: count=%0d want one commit q=4 w=49", cq.size()); end
    endtask

    task automatic test_free_collide();
        int f, l;
        checks++; if (dut.occ[0] !== 19'd2) begin errors++; $display("FAIL collide_pre_occ: got %0d want 2", dut.occ[0]); end
        send_pkt(5'b00001, 3, 6'd32, 8, 1, 3'd0, 19'd2, f, l);
        repeat (3) @(negedge clk);
        checks++; if (dut.occ[0] !== 19'd4) begin errors++; $display("FAIL collide_occ: got %0d want 4", dut.occ[0]); end
        pulse_free(3'd5, 19'd1);
        checks++; if (dut.occ[0] !== 19'd4) begin errors++; $display("FAIL collide_badq: got %0d want 4", dut.occ[0]); end
    endtask

    task automatic test_reset_mid();
        int f, l;
        clear_logs();
        din_oq = 5'b00100; din_valid = 1'b1; din_last = 1'b0; din_bytes = 6'd32;
        for (int k = 0; k < 2; k++) begin din_data = dat(11, k); @(negedge clk); end
        din_valid = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cq.size() != 0) begin errors++; $display("FAIL mid_commit: got %0d commits want 0", cq.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (dut.wr_ptr[i] !== 19'(i*QS) || dut.occ[i] !== 19'd0) begin
                errors++; $display("FAIL mid_ptr%0d: ptr=%0d occ=%0d want %0d 0", i, dut.wr_ptr[i], dut.occ[i], i*QS); end
        end
        clear_logs();
        send_pkt(5'b00100, 1, 6'd3, 12, -1, 3'd0, 19'd0, f, l);
        repeat (3) @(negedge clk);
        checks++; if (wa.size() != 2 || wa[0] !== 19'(2*QS+1) || wa[1] !== 19'(2*QS)) begin
            errors++; $display("FAIL mid_after: writes=%0d want data %0d then header %0d", wa.size(), 2*QS+1, 2*QS); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_drop();
        test_wrap();
        test_trunc();
        test_free_collide();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/oq_fifo2mem_writer.md
Name: oq_fifo2mem_writer

Overview:
- Downstream stage of the AXI-to-FIFO front end in the SRAM output-queue core.
- Consumes cropped packet words (data, valid-byte count, last flag, one-hot destination queue) and writes them into per-queue circular regions of the shared SRAM.
- Prepends a length header to each packet, tracks per-queue occupancy, drops packets that do not fit, and signals committed packets to the read side.

Parameters:
DATA_WIDTH, 256, data bits per memory word
BYTE_CNT_WIDTH, 6, width of valid-byte count (1..32)
NUM_QUEUES, 5, number of output queues
QUEUE_ID_WIDTH, 3, binary queue index width
MEM_ADDR_WIDTH, 19, SRAM word address width
QUEUE_SIZE, 104857, words per queue region; queue q base = q*QUEUE_SIZE
MAX_PKT_WORDS, 48, max data words per packet

Ports:
clk  in  1  core clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
din_data  in  DATA_WIDTH  packet data word
din_bytes  in  BYTE_CNT_WIDTH  valid bytes in word (1..32)
din_last  in  1  last word of packet
din_oq  in  NUM_QUEUES  one-hot destination; sampled on first word only
din_valid  in  1  input word valid
din_ready  out  1  block accepts word when din_valid & din_ready
mem_wr_en  out  1  SRAM write strobe (registered)
mem_wr_addr  out  MEM_ADDR_WIDTH  SRAM write address (registered)
mem_wr_data  out  DATA_WIDTH  SRAM write data (registered)
free_valid  in  1  read side returns space
free_queue  in  QUEUE_ID_WIDTH  queue being freed
free_words  in  MEM_ADDR_WIDTH  words freed (header + data)
pkt_commit  out  1  one-cycle pulse: packet fully written
commit_queue  out  QUEUE_ID_WIDTH  queue of committed packet
commit_words  out  MEM_ADDR_WIDTH  words committed (data + 1 header)
pkt_drop  out  1  one-cycle pulse: packet discarded at admission
drop_queue  out  QUEUE_ID_WIDTH  queue of dropped packet

Behaviour:
- Reset: state IDLE; din_ready=0 during reset, 1 afterwards in IDLE; mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0; pkt_commit=0, pkt_drop=0, commit/drop fields 0; per-queue wr_ptr=base, occ=0. Reset mid-packet discards the partial packet with no commit.
- States: IDLE, WRITE, DROP, HDR. din_ready=1 in IDLE/WRITE/DROP, 0 in HDR.
- IDLE, word accepted: q = lowest set bit of din_oq.
  - Drop if din_oq==0 or QUEUE_SIZE-occ[q] < MAX_PKT_WORDS+1. Pulse pkt_drop (drop_queue=q, 0 if din_oq==0) next cycle. Next state: last ? IDLE : DROP.
  - Otherwise admit: hdr_addr=wr_ptr[q]. Write data at wr_ptr[q]+1 (wrapped). Set wcnt=1, bytes=din_bytes. Next state: last ? HDR : WRITE.
- WRITE: each accepted word is written at the next wrapped address. wcnt++, bytes+=din_bytes. If wcnt reaches MAX_PKT_WORDS, later words are consumed without a write and trunc=1. On last: go HDR.
- DROP: consume words without writing; on last: go IDLE.
- HDR: one cycle. Write the header at hdr_addr:
  - bits[15:0]=bytes, [31:16]=wcnt, [32]=trunc, other bits 0.
  - Pulse pkt_commit in the same cycle mem_wr_en carries the header (commit_queue=q, commit_words=wcnt+1).
  - wr_ptr[q] advances past the last data word; return to IDLE.
- Write latency: a word accepted in cycle N appears on the mem port in cycle N+1; the header appears in cycle M+2 for last accepted in cycle M. At most one write per cycle.
- Address wrap: the address after base+QUEUE_SIZE-1 is base. The header may sit at the top of a region with data starting at base.
- occ[q] increments by 1 per SRAM write to q (data and header).
- free_valid: occ[free_queue] -= free_words.
  - Same-cycle write and free on the same queue apply both (net change).
  - Underflow saturates at 0.
  - free_queue >= NUM_QUEUES is ignored.
- Admission uses occ as of the accept cycle, including writes still in flight.
- Arithmetic: bytes is 16 bits and wraps; no overflow check needed for MAX_PKT_WORDS*32.

Test Plan:
- Reset, then 3-word packet to din_oq=5'b00100, bytes 32,32,10 -> data at 2*QUEUE_SIZE+1..+3, then header at 2*QUEUE_SIZE {bytes=74, words=3, trunc=0}; pkt_commit with commit_queue=2, commit_words=4; occ[2]=4.
- 1-word packet (din_last on first word, 60-byte case split: bytes=20) to queue 0 -> data at addr 1, header at addr 0 next cycle; din_ready low exactly one cycle.
- Fill queue 1 until free=48 words, send packet -> pkt_drop with drop_queue=1, no mem_wr_en for any word; free_valid q1 free_words=100 -> next packet admitted.
- wr_ptr[3]=4*QUEUE_SIZE-2, 3-word packet -> header at 4*QUEUE_SIZE-2, data at 4*QUEUE_SIZE-1, 3*QUEUE_SIZE, 3*QUEUE_SIZE+1.
- 50-word packet to queue 4 -> 48 data writes, header words=48 trunc=1, commit_words=49.
- free_valid on queue 0 in the same cycle as a queue-0 data write -> occ net (+1 - free_words). Assert reset during WRITE -> no commit; all pointers return to base.
